button_event_ctrl: RTL and testbench

- Avalon-MM slave controller for the audio player's push-buttons (play/pause, stop, next, prev).
- Synchronises and debounces each button, then detects press edges.
- Latches press events in a write-1-to-clear capture register and raises a maskable interrupt to the Nios II CPU.
- Replaces direct polling of raw button levels; sits between the board KEY pins and the system interconnect.

---
 rtl/button_event_ctrl.sv | 106 ++++++++++
 tb/tb_button_event_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/button_event_ctrl.sv
// Avalon-MM push-button controller: 2-flop sync, per-button debounce, press-edge
// capture with write-1-to-clear, and a maskable level interrupt.
module button_event_ctrl #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [WIDTH-1:0] RELEASED = (ACTIVE_LOW != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
  logic             irq_q, irq_d;
  logic [31:0]      readdata_q, readdata_d;

  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] press;
  logic [WIDTH-1:0] clear;
  logic             wr_en;

  // Bits above WIDTH are defined as ignored on write.
  logic unused_writedata;
  assign unused_writedata = ^writedata[31:WIDTH];

  always_comb begin
    sync1_d = in_port;
    sync2_d = sync1_q;
    sync    = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

    stable_d = stable_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = sync[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end

    // Press is taken from the next-state so capture sets in the same cycle stable rises;
    // OR-ing it in last makes a simultaneous set beat a W1C clear.
    press = stable_d & ~stable_q;
    wr_en = chipselect & ~write_n;

    irq_mask_d = irq_mask_q;
    clear      = '0;
    if (wr_en && address == 2'd2) irq_mask_d = writedata[WIDTH-1:0];
    if (wr_en && address == 2'd3) clear      = writedata[WIDTH-1:0];

    edge_capture_d = (edge_capture_q & ~clear) | press;
    irq_d          = |(edge_capture_q & irq_mask_q);

    case (address)
      2'd0:    readdata_d = 32'(stable_q);
      2'd1:    readdata_d = 32'(sync);
      2'd2:    readdata_d = 32'(irq_mask_q);
      default: readdata_d = 32'(edge_capture_q);
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q        <= RELEASED;
      sync2_q        <= RELEASED;
      stable_q       <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      irq_mask_q     <= '0;
      edge_capture_q <= '0;
      irq_q          <= 1'b0;
      readdata_q     <= '0;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      stable_q       <= stable_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      irq_mask_q     <= irq_mask_d;
      edge_capture_q <= edge_capture_d;
      irq_q          <= irq_d;
      readdata_q     <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl with an 8-cycle debounce window.
module tb_button_event_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  in_port;
  logic        irq;

  int total = 0;
  int bad   = 0;

  button_event_ctrl #(
    .WIDTH(4), .DEBOUNCE_CYCLES(8), .CNT_W(4), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; in_port = 4'hF; address = 2'd0;
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    tick(3);
    total++; if (readdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_readdata got=%h exp=%h", readdata, 32'h0); end
    total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL reset_irq got=%b exp=0", irq); end
    reset_n = 1'b1;
    tick(12);
    total++; if (readdata !== 32'h0) begin bad++; $display("[TB] FAIL idle_addr0 got=%h exp=%h", readdata, 32'h0); end
    address = 2'd1;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      total++; if (readdata !== 32'h0) begin bad++; $display("[TB] FAIL idle_addr1 cyc=%0d got=%h exp=%h", i, readdata, 32'h0); end
    end
  endtask

  task automatic test_clean_press;
    address = 2'd1;
    in_port = 4'hE;
    // sync lands at edge 2; readdata shows it one edge later.
    tick(2);
    total++; if (readdata !== 32'h0) begin bad++; $display("[TB] FAIL press_sync_early got=%h exp=%h", readdata, 32'h0); end
    tick(1);
    total++; if (readdata !== 32'h1) begin bad++; $display("[TB] FAIL press_sync got=%h exp=%h", readdata, 32'h1); end
    address = 2'd0;
    // stable rises at edge 10; readdata reflects it at edge 11.
    tick(7);
    total++; if (readdata !== 32'h0) begin bad++; $display("[TB] FAIL press_stable_early got=%h exp=%h", readdata, 32'h0); end
    tick(1);
    total++; if (readdata !== 32'h1) begin bad++; $display("[TB] FAIL press_stable got=%h exp=%h", readdata, 32'h1); end
    address = 2'd3;
    tick(1);
    total++; if (readdata !== 32'h1) begin bad++; $display("[TB] FAIL press_capture got=%h exp=%h", readdata, 32'h1); end
    total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL press_irq_masked got=%b exp=0", irq); end
    bus_write(2'd3, 32'h1);
    tick(1);
    total++; if (readdata !== 32'h0) begin bad++; $display("[TB] FAIL press_w1c got=%h exp=%h", readdata, 32'h0); end
    in_port = 4'hF;
    tick(14);
    total++; if (readdata !== 32'h0) begin bad++; $display("[TB] FAIL release_no_event got=%h exp=%h", readdata, 32'h0); end
    address = 2'd0;
    tick(1);
    total++; if (readdata !== 32'h0) begin bad++; $display("[TB] FAIL release_stable got=%h exp=%h", readdata, 32'h0); end
  endtask

  task automatic test_bounce;
    address = 2'd0;
    for (int r = 0; r < 4; r++) begin
      in_port = 4'hD;
      for (int i = 0; i < 5; i++) begin
        tick(1);
        total++; if (readdata !== 32'h0) begin bad++; $display("[TB] FAIL bounce_low r=%0d i=%0d got=%h exp=%h", r, i, readdata, 32'h0); end
      end
      in_port = 4'hF;
      for (int i = 0; i < 3; i++) begin
        tick(1);
        total++; if (readdata !== 32'h0) begin bad++; $display("[TB] FAIL bounce_high r=%0d i=%0d got=%h exp=%h", r, i, readdata, 32'h0); end
      end
    end
    tick(12);
    total++; if (readdata !== 32'h0) begin bad++; $display("[TB] FAIL bounce_settled got=%h exp=%h", readdata, 32'h0); end
    address = 2'd3;
    tick(1);
    total++; if (readdata !== 32'h0) begin bad++; $display("[TB] FAIL bounce_capture got=%h exp=%h", readdata, 32'h0); end
  endtask

  task automatic test_irq_w1c;
    bus_write(2'd2, 32'h4);
    address = 2'd2;
    tick(1);
    total++; if (readdata !== 32'h4) begin bad++; $display("[TB] FAIL mask_readback got=%h exp=%h", readdata, 32'h4); end
    address = 2'd3;
    in_port = 4'hB;
    // capture sets at edge 10, irq follows at edge 11.
    tick(10);
    total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL irq_early got=%b exp=0", irq); end
    tick(1);
    total++; if (irq !== 1'b1) begin bad++; $display("[TB] FAIL irq_set got=%b exp=1", irq); end
    total++; if (readdata !== 32'h4) begin bad++; $display("[TB] FAIL irq_capture got=%h exp=%h", readdata, 32'h4); end
    bus_write(2'd3, 32'h4);
    tick(1);
    total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL irq_cleared got=%b exp=0", irq); end
    total++; if (readdata !== 32'h0) begin bad++; $display("[TB] FAIL irq_w1c got=%h exp=%h", readdata, 32'h0); end
    in_port = 4'hF;
    tick(14);
    total++; if (readdata !== 32'h0) begin bad++; $display("[TB] FAIL irq_release got=%h exp=%h", readdata, 32'h0); end
    total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL irq_release_irq got=%b exp=0", irq); end
  endtask

  task automatic test_collision;
    address = 2'd3;
    in_port = 4'h7;
    tick(9);
    // W1C is live on edge 10, the same edge stable[3] rises.
    bus_write(2'd3, 32'h8);
    tick(1);
    total++; if (readdata !== 32'h8) begin bad++; $display("[TB] FAIL collision_set_wins got=%h exp=%h", readdata, 32'h8); end
    in_port = 4'hF;
    tick(12);
    bus_write(2'd3, 32'h8);
    tick(1);
    total++; if (readdata !== 32'h0) begin bad++; $display("[TB] FAIL collision_clear got=%h exp=%h", readdata, 32'h0); end
    total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL collision_irq got=%b exp=0", irq); end
  endtask

  task automatic test_multi;
    address = 2'd3;
    in_port = 4'h6;
    tick(12);
    total++; if (readdata !== 32'h9) begin bad++; $display("[TB] FAIL multi_capture got=%h exp=%h", readdata, 32'h9); end
    address = 2'd0;
    tick(1);
    total++; if (readdata !== 32'h9) begin bad++; $display("[TB] FAIL multi_stable got=%h exp=%h", readdata, 32'h9); end
    total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL multi_irq got=%b exp=0", irq); end
    in_port = 4'hF;
    tick(12);
    bus_write(2'd3, 32'hF);
    tick(1);
    total++; if (readdata !== 32'h0) begin bad++; $display("[TB] FAIL multi_clear got=%h exp=%h", readdata, 32'h0); end
  endtask

  task automatic test_reset_mid;
    address = 2'd3;
    in_port = 4'hD;
    // counter reaches 4 at edge 6 after the pin change.
    tick(6);
    reset_n = 1'b0;
    #2;
    total++; if (readdata !== 32'h0) begin bad++; $display("[TB] FAIL midreset_readdata got=%h exp=%h", readdata, 32'h0); end
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      total++; if (readdata !== 32'h0) begin bad++; $display("[TB] FAIL midreset_no_event cyc=%0d got=%h exp=%h", i, readdata, 32'h0); end
    end
    address = 2'd0;
    // held press re-synchronises from scratch: stable at edge 10, readdata at edge 11.
    tick(2);
    total++; if (readdata !== 32'h0) begin bad++; $display("[TB] FAIL midreset_restart_early got=%h exp=%h", readdata, 32'h0); end
    tick(1);
    total++; if (readdata !== 32'h2) begin bad++; $display("[TB] FAIL midreset_restart got=%h exp=%h", readdata, 32'h2); end
    total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL midreset_irq got=%b exp=0", irq); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_irq_w1c();
    test_collision();
    test_multi();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
